// File: rtl/pipe_skid_reg_if.sv
//------------------------------------------------------------------------------
// Module      : pipe_skid_reg_if
// Description : Valid/ready handshake bundle for one pipeline stage.
//               Upstream side  : in_valid, in_ready, in_data
//               Downstream side: out_valid, out_ready, out_data
//               modport slave  - the stage register itself
//               modport master - the surrounding environment, which drives
//                                the upstream payload and consumes the output
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pipe_skid_reg_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
//------------------------------------------------------------------------------
// Module      : pipe_skid_reg
// Description : Flow-controlled pipeline stage register with a two-entry skid
//               buffer. in_ready is a function of state (and rst) only, so the
//               back-pressure path from out_ready is broken at this stage.
//               A synchronous flush squashes all held entries.
// Ports       : clk       - clock, rising edge
//               rst       - synchronous active-high reset
//               flush     - squash held entries (synchronous)
//               occupancy - number of valid entries held (0..2)
//               bus       - handshake bundle (slave side)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_skid_reg #(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] PRESET_VAL = '0,
    parameter bit                FLUSH_CLR  = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    output logic [1:0]    occupancy,
    pipe_skid_reg_if.slave bus
);

    // Main register M drives the outputs; skid register S holds the payload
    // accepted while downstream was stalled. S is always younger than M.
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              r_s_valid;
    logic [DATA_W-1:0] r_s_data;

    logic w_in_ready;
    logic w_in_fire;
    logic w_out_fire;
    logic w_m_load_in;
    logic w_m_load_s;
    logic w_s_load_in;

    assign w_in_ready = ~r_s_valid & ~rst;
    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = r_m_valid & bus.out_ready;

    // Payload enables. in_fire implies S is empty, so the stage is EMPTY or
    // ONE whenever w_in_fire is set. A flush suppresses every load.
    assign w_m_load_in = ~flush & w_in_fire & (~r_m_valid | w_out_fire);
    assign w_s_load_in = ~flush & w_in_fire & r_m_valid & ~w_out_fire;
    assign w_m_load_s  = ~flush & r_s_valid & w_out_fire;

    // Valid bits: (m,s) = (0,0) EMPTY, (1,0) ONE, (1,1) FULL.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (!r_m_valid) begin
            if (w_in_fire) begin
                r_m_valid <= 1'b1;
            end
        end else if (!r_s_valid) begin
            if (w_in_fire && !w_out_fire) begin
                r_s_valid <= 1'b1;
            end else if (!w_in_fire && w_out_fire) begin
                r_m_valid <= 1'b0;
            end
        end else if (w_out_fire) begin
            r_s_valid <= 1'b0;
        end
    end

    // Payload registers: loaded only on the transitions that need them so
    // idle cycles do not toggle the wide data path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_data <= PRESET_VAL;
            r_s_data <= PRESET_VAL;
        end else if (flush) begin
            if (FLUSH_CLR) begin
                r_m_data <= PRESET_VAL;
                r_s_data <= PRESET_VAL;
            end
        end else begin
            if (w_m_load_in) begin
                r_m_data <= bus.in_data;
            end else if (w_m_load_s) begin
                r_m_data <= r_s_data;
            end
            if (w_s_load_in) begin
                r_s_data <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_m_valid;
    assign bus.out_data  = r_m_data;
    assign occupancy     = {1'b0, r_m_valid} + {1'b0, r_s_valid};

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
//------------------------------------------------------------------------------
// Module      : tb_pipe_skid_reg
// Description : Self-checking bench for pipe_skid_reg. Two instances share
//               stimulus: dut clears payload on flush, dut0 holds it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_skid_reg;

    localparam int          c_dw     = 16;
    localparam logic [15:0] c_preset = 16'hBEEF;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [1:0] occ;
    logic [1:0] occ0;

    pipe_skid_reg_if #(.DATA_W(c_dw)) bus ();
    pipe_skid_reg_if #(.DATA_W(c_dw)) bus0 ();

    assign bus0.in_valid  = bus.in_valid;
    assign bus0.in_data   = bus.in_data;
    assign bus0.out_ready = bus.out_ready;

    pipe_skid_reg #(.DATA_W(c_dw), .PRESET_VAL(c_preset), .FLUSH_CLR(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .occupancy (occ),
        .bus       (bus)
    );

    pipe_skid_reg #(.DATA_W(c_dw), .PRESET_VAL(c_preset), .FLUSH_CLR(1'b0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .occupancy (occ0),
        .bus       (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [15:0] e_od;
        logic [15:0] e_od0;
        logic        e_rdy;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic iv, input logic [15:0] d,
                       input logic ordy, input logic fl, input logic e_ov,
                       input logic [15:0] e_od, input logic [15:0] e_od0,
                       input logic e_rdy, input logic [1:0] e_occ);
        vec_t v;
        v.rst = r; v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.e_od = e_od; v.e_od0 = e_od0;
        v.e_rdy = e_rdy; v.e_occ = e_occ;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic iv, input logic [15:0] d,
                         input logic ordy, input logic fl);
        rst           = r;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
    endtask

    logic [15:0] sb[$];
    logic        m_ov;
    logic        m_in_fire;
    logic        m_out_fire;
    logic        r_iv;
    logic        r_or;
    logic        r_fl;
    logic [15:0] r_d;
    logic [63:0] act_t;
    logic [63:0] exp_t;
    logic [15:0] head;

    initial begin
        drive(1'b1, 1'b1, 16'h0011, 1'b0, 1'b0);
        tick();

        //    rst iv  data     or  fl   ov  od       od0      rdy occ
        add(1, 1, 16'h0011, 0, 0,   0, c_preset, c_preset, 0, 0);
        add(1, 1, 16'h0011, 0, 0,   0, c_preset, c_preset, 0, 0);
        add(1, 1, 16'h0011, 0, 0,   0, c_preset, c_preset, 0, 0);
        add(0, 0, 16'h0000, 0, 0,   0, c_preset, c_preset, 1, 0);
        // skid fill and drain
        add(0, 1, 16'h000A, 0, 0,   0, c_preset, c_preset, 1, 0);
        add(0, 1, 16'h000B, 0, 0,   1, 16'h000A, 16'h000A, 1, 1);
        add(0, 1, 16'h000C, 0, 0,   1, 16'h000A, 16'h000A, 0, 2);
        add(0, 0, 16'h0000, 1, 0,   1, 16'h000A, 16'h000A, 0, 2);
        add(0, 0, 16'h0000, 1, 0,   1, 16'h000B, 16'h000B, 1, 1);
        add(0, 0, 16'h0000, 0, 0,   0, 16'h000B, 16'h000B, 1, 0);
        // flush in FULL with concurrent out_fire
        add(0, 1, 16'h000A, 0, 0,   0, 16'h000B, 16'h000B, 1, 0);
        add(0, 1, 16'h000B, 0, 0,   1, 16'h000A, 16'h000A, 1, 1);
        add(0, 0, 16'h0000, 1, 1,   1, 16'h000A, 16'h000A, 0, 2);
        add(0, 0, 16'h0000, 0, 0,   0, c_preset, 16'h000A, 1, 0);
        // flush with concurrent in_fire
        add(0, 1, 16'h000C, 1, 1,   0, c_preset, 16'h000A, 1, 0);
        add(0, 0, 16'h0000, 1, 0,   0, c_preset, 16'h000A, 1, 0);
        // ONE with simultaneous in_fire and out_fire
        add(0, 1, 16'h0001, 1, 0,   0, c_preset, 16'h000A, 1, 0);
        add(0, 1, 16'h0002, 1, 0,   1, 16'h0001, 16'h0001, 1, 1);
        add(0, 0, 16'h0000, 1, 0,   1, 16'h0002, 16'h0002, 1, 1);
        add(0, 0, 16'h0000, 1, 0,   0, 16'h0002, 16'h0002, 1, 0);
        // reset mid-operation from FULL
        add(0, 1, 16'h0005, 0, 0,   0, 16'h0002, 16'h0002, 1, 0);
        add(0, 1, 16'h0006, 0, 0,   1, 16'h0005, 16'h0005, 1, 1);
        add(1, 1, 16'h0007, 1, 0,   1, 16'h0005, 16'h0005, 0, 2);
        add(0, 0, 16'h0000, 0, 0,   0, c_preset, c_preset, 1, 0);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].iv, vq[i].d, vq[i].ordy, vq[i].fl);
            #1;
            check($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'(vq[i].e_ov));
            check($sformatf("vec%0d out_data", i),  64'(bus.out_data),  64'(vq[i].e_od));
            check($sformatf("vec%0d in_ready", i),  64'(bus.in_ready),  64'(vq[i].e_rdy));
            check($sformatf("vec%0d occupancy", i), 64'(occ),           64'(vq[i].e_occ));
            check($sformatf("vec%0d out_data_hold", i), 64'(bus0.out_data), 64'(vq[i].e_od0));
            check($sformatf("vec%0d occupancy_hold", i), 64'(occ0), 64'(vq[i].e_occ));
            tick();
        end

        // Streaming 0x1..0x10 with downstream always ready.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b1, 16'(i), 1'b1, 1'b0);
            #1;
            check("stream in_ready", 64'(bus.in_ready), 64'd1);
            if (i > 1) begin
                check("stream out", 64'({bus.out_valid, bus.out_data}),
                      64'({1'b1, 16'(i - 1)}));
            end
            tick();
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        #1;
        check("stream last", 64'({bus.out_valid, bus.out_data}), 64'({1'b1, 16'h0010}));
        tick();
        check("stream drained", 64'(bus.out_valid), 64'd0);

        // Random traffic against a queue scoreboard.
        sb.delete();
        for (int c = 0; c < 10000; c++) begin
            r_iv = ($urandom_range(0, 9) < 7);
            r_or = ($urandom_range(0, 9) < 6);
            r_fl = ($urandom_range(0, 99) < 3);
            r_d  = 16'($urandom);
            drive(1'b0, r_iv, r_d, r_or, r_fl);
            #1;
            m_ov = (sb.size() != 0);
            head = m_ov ? sb[0] : 16'h0000;
            act_t = {25'd0, bus.out_valid, bus.in_ready, occ,
                     (bus.out_valid ? bus.out_data : 16'h0000),
                     bus0.out_valid, occ0,
                     (bus0.out_valid ? bus0.out_data : 16'h0000)};
            exp_t = {25'd0, m_ov, (sb.size() < 2), 2'(sb.size()), head,
                     m_ov, 2'(sb.size()), head};
            check("random state", act_t, exp_t);
            m_out_fire = m_ov & r_or;
            m_in_fire  = r_iv & (sb.size() < 2);
            if (m_out_fire) void'(sb.pop_front());
            if (r_fl) sb.delete();
            else if (m_in_fire) sb.push_back(r_d);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised, flow-controlled pipeline stage register: the successor to the fixed-field stage registers between IF/ID/EX/MEM/WB. It carries one DATA_W-bit payload plus a valid bit using a valid/ready handshake, with a two-entry skid buffer so that in_ready is a registered signal that breaks the combinational back-pressure path. A synchronous flush squashes in-flight entries for branch/hazard recovery, replacing ad-hoc bubble logic built from per-stage enables.

## Interface
- DATA_W, default 64: payload width in bits; legal range 1..256.
- PRESET_VAL, default 0: value loaded into the payload registers on reset, and on flush when FLUSH_CLR=1.
- FLUSH_CLR, default 0: 1 = flush also loads PRESET_VAL into the payload registers; 0 = flush clears valid bits only.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  upstream presents a payload.
- in_ready  out  1  stage accepts a payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage presents a payload.
- out_ready  in  1  downstream accepts a payload this cycle.
- out_data  out  DATA_W  payload presented downstream.
- flush  in  1  squash all held entries; synchronous.
- occupancy  out  2  number of valid entries held (0, 1 or 2).

## Operation
- Storage:
  - main register M (m_valid, m_data) drives the outputs: out_valid = m_valid, out_data = m_data.
  - skid register S (s_valid, s_data) holds a payload accepted while downstream stalled.
- Fire conditions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !s_valid & !rst. It depends only on state, never on out_ready.
- occupancy = m_valid + s_valid.
- States, encoded by (m_valid, s_valid): EMPTY (0,0), ONE (1,0), FULL (1,1). (0,1) is illegal and must never be reached.
- EMPTY:
  - in_fire -> ONE, M <= in_data.
  - otherwise stay in EMPTY.
- ONE:
  - in_fire & out_fire -> ONE, M <= in_data.
  - in_fire & !out_fire -> FULL, S <= in_data.
  - !in_fire & out_fire -> EMPTY.
  - neither -> stay in ONE, M holds.
- FULL:
  - in_ready = 0, so in_fire cannot occur.
  - out_fire -> ONE, M <= S.
  - otherwise stay in FULL, both registers hold.
- Ordering: strict FIFO. The payload in S is always younger than the payload in M. No payload is duplicated or dropped except by flush or rst.
- flush = 1 (ignored while rst = 1):
  - next state EMPTY; m_valid and s_valid are cleared.
  - an in_fire in the same cycle is discarded; upstream must treat it as squashed.
  - an out_fire in the same cycle is completed; downstream has consumed the payload.
  - FLUSH_CLR=1: m_data and s_data <= PRESET_VAL. FLUSH_CLR=0: data registers hold their values.
- rst = 1: m_valid = s_valid = 0, m_data = s_data = PRESET_VAL. rst has priority over flush and over all handshakes.
- Data registers load only on the transitions listed above. Payload-register enables are gated so idle cycles produce no toggling.

## Timing
- Reset values:
  - out_valid = 0, out_data = PRESET_VAL, occupancy = 0.
  - in_ready = 0 while rst is high, and 1 in the first cycle after rst deasserts.
- Latency: payload accepted at edge N appears on out_data/out_valid after edge N (one cycle), when the stage was EMPTY, or ONE with out_fire in that cycle.
- Throughput: one transfer per cycle sustained whenever out_ready stays high.
- Back-pressure:
  - in_ready falls one cycle after the first stalled cycle (ONE -> FULL).
  - in_ready rises one cycle after out_fire in FULL.
- Combinational paths:
  - no path from out_ready to in_ready.
  - no path from in_* to out_*.
  - flush affects outputs only after the next edge.
- Reset mid-operation: held entries are lost, no partial transfer completes, and outputs show reset values from the cycle after the edge at which rst is sampled.

## Test plan
- Reset and idle: assert rst 3 cycles with in_valid=1 -> out_valid=0, out_data=PRESET_VAL, in_ready=0; after release, in_ready=1 and occupancy=0.
- Streaming:
  - stimulus: out_ready=1, push 0x1..0x10 back-to-back.
  - required: outputs 0x1..0x10 in order, one per cycle, each one cycle after its input; in_ready never drops.
- Skid fill/drain:
  - stimulus: push 0xA, 0xB with out_ready=0.
  - required: occupancy reaches 2 and in_ready=0.
  - stimulus: raise out_ready.
  - required: 0xA then 0xB emitted on consecutive cycles; in_ready=1 one cycle after 0xA leaves.
- Flush in FULL with concurrent handshake:
  - stimulus: stage holds 0xA, 0xB; pulse flush with out_ready=1.
  - required: 0xA is consumed and 0xB is squashed; next cycle out_valid=0, occupancy=0.
  - FLUSH_CLR=1 additionally requires out_data=PRESET_VAL.
- Flush with concurrent input: flush=1 and in_fire of 0xC in the same cycle -> 0xC never appears on the output.
- Randomised traffic: random in_valid/out_ready/flush for 10k cycles against a queue scoreboard -> exact ordering; state (0,1) never reached; occupancy always equals the scoreboard depth.
